// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: turns PS/2 Set 2 scan bytes into key events with Shift/Caps tracking and ASCII.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] datain,
  input  logic       dataready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] ascii,
  output logic       shift_on,
  output logic       caps_on
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] IDLE = 3'd0, EXT = 3'd1, BRK = 3'd2, EXT_BRK = 3'd3, SKIP = 3'd4;
  logic          rdy_q, acc, pfx, junk, em, em_ext, em_brk;
  logic          pend, p_ext, p_brk, lsh, rsh, caps_held;
  logic [2:0]    state, nstate, skip_cnt, nskip;
  logic [TW-1:0] tcnt;
  logic [7:0]    p_code, lc, sym, asc;
  function automatic logic [7:0] letter(input logic [7:0] c);
    case (c)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63; 8'h23: letter = 8'h64;
      8'h24: letter = 8'h65; 8'h2B: letter = 8'h66; 8'h34: letter = 8'h67; 8'h33: letter = 8'h68;
      8'h43: letter = 8'h69; 8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F; 8'h4D: letter = 8'h70;
      8'h15: letter = 8'h71; 8'h2D: letter = 8'h72; 8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74;
      8'h3C: letter = 8'h75; 8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      default: letter = 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] symbol(input logic [7:0] c);
    case (c)
      8'h45: symbol = 8'h30; 8'h16: symbol = 8'h31; 8'h1E: symbol = 8'h32; 8'h26: symbol = 8'h33;
      8'h25: symbol = 8'h34; 8'h2E: symbol = 8'h35; 8'h36: symbol = 8'h36; 8'h3D: symbol = 8'h37;
      8'h3E: symbol = 8'h38; 8'h46: symbol = 8'h39; 8'h29: symbol = 8'h20; 8'h5A: symbol = 8'h0D;
      8'h66: symbol = 8'h08; 8'h0D: symbol = 8'h09; 8'h76: symbol = 8'h1B;
      default: symbol = 8'h00;
    endcase
  endfunction
  assign acc      = dataready & ~rdy_q;
  assign pfx      = datain inside {8'hE0, 8'hF0, 8'hE1};
  assign junk     = datain inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  assign shift_on = lsh | rsh;
  assign lc       = letter(p_code);
  assign sym      = symbol(p_code);
  // Shift/Caps are read before this event's own update lands on the same edge.
  assign asc = (p_ext | p_brk) ? 8'h00 : (lc != 8'h00) ? ((shift_on ^ caps_on) ? lc - 8'h20 : lc) : sym;
  always_comb begin
    nstate = state;
    nskip  = skip_cnt;
    em     = 1'b0;
    em_ext = 1'b0;
    em_brk = 1'b0;
    case (state)
      IDLE: begin
        nstate = (datain == 8'hE0) ? EXT : (datain == 8'hF0) ? BRK : (datain == 8'hE1) ? SKIP : IDLE;
        nskip  = (datain == 8'hE1) ? 3'd7 : skip_cnt;
        em     = ~pfx & ~junk;
      end
      EXT: begin
        nstate = (datain == 8'hF0) ? EXT_BRK : (datain == 8'hE0) ? EXT : IDLE;
        em     = (datain != 8'hF0) && (datain != 8'hE0);
        em_ext = 1'b1;
      end
      BRK: begin
        nstate = IDLE;
        em     = ~pfx;
        em_brk = 1'b1;
      end
      EXT_BRK: begin
        nstate = IDLE;
        em     = ~pfx;
        em_ext = 1'b1;
        em_brk = 1'b1;
      end
      SKIP: begin
        nskip  = skip_cnt - 3'd1;
        nstate = (skip_cnt == 3'd1) ? IDLE : SKIP;
      end
      default: nstate = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdy_q    <= 1'b0;
      state    <= IDLE;
      skip_cnt <= 3'd0;
      tcnt     <= '0;
      pend     <= 1'b0;
      p_code   <= 8'h00;
      p_ext    <= 1'b0;
      p_brk    <= 1'b0;
    end else begin
      rdy_q <= dataready;
      pend  <= acc & em;
      if (acc & em) begin
        p_code <= datain;
        p_ext  <= em_ext;
        p_brk  <= em_brk;
      end
      // An accepted byte always wins over a timeout expiring in the same cycle.
      if (acc) begin
        state    <= nstate;
        skip_cnt <= nskip;
        tcnt     <= '0;
      end else if (state != IDLE) begin
        if (tcnt == TLAST) begin
          state    <= IDLE;
          skip_cnt <= 3'd0;
          tcnt     <= '0;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      ascii     <= 8'h00;
      lsh       <= 1'b0;
      rsh       <= 1'b0;
      caps_on   <= 1'b0;
      caps_held <= 1'b0;
    end else begin
      key_valid <= pend;
      if (pend) begin
        key_code  <= p_code;
        key_ext   <= p_ext;
        key_break <= p_brk;
        ascii     <= asc;
        if (!p_ext) begin
          if (p_code == 8'h12) lsh <= ~p_brk;
          if (p_code == 8'h59) rsh <= ~p_brk;
          // Typematic repeats of Caps arrive while held and must not re-toggle.
          if (p_code == 8'h58) begin
            if (!p_brk && !caps_held) caps_on <= ~caps_on;
            caps_held <= ~p_brk;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed and random byte streams checked against a keystroke-level model.
module tb_ps2_scan_decoder;
  localparam int TO = 64;
  localparam logic [7:0] LT[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DG[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] JK[6]  = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic       shift;
    logic       caps;
  } ev_t;
  logic       clk = 1'b0, reset = 1'b1, dataready = 1'b0;
  logic [7:0] datain = 8'h00;
  logic       key_valid, key_ext, key_break, shift_on, caps_on;
  logic [7:0] key_code, ascii;
  ev_t        exp_q[$], obs_q[$];
  int         vectors = 0, miscompares = 0;
  int         m_skip = 0;
  bit         m_ext = 0, m_brk = 0, m_ls = 0, m_rs = 0, m_caps = 0, m_held = 0;
  ps2_scan_decoder #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .datain(datain), .dataready(dataready),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .ascii(ascii), .shift_on(shift_on), .caps_on(caps_on)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (key_valid === 1'b1) obs_q.push_back('{key_code, key_ext, key_break, ascii, shift_on, caps_on});
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit up);
    for (int i = 0; i < 26; i++) if (LT[i] == c) return up ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++) if (DG[i] == c) return 8'(8'h30 + i);
    case (c)
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h0D: return 8'h09;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction
  task automatic model_emit(input logic [7:0] c, input bit e, input bit b);
    ev_t x;
    x.code  = c;
    x.ext   = e;
    x.brk   = b;
    x.ascii = (e || b) ? 8'h00 : ref_ascii(c, (m_ls | m_rs) ^ m_caps);
    if (!e && c == 8'h12) m_ls = !b;
    if (!e && c == 8'h59) m_rs = !b;
    if (!e && c == 8'h58) begin
      if (!b && !m_held) m_caps = !m_caps;
      m_held = !b;
    end
    x.shift = m_ls | m_rs;
    x.caps  = m_caps;
    exp_q.push_back(x);
  endtask
  task automatic model_byte(input logic [7:0] b);
    bit is_pfx, is_junk;
    is_pfx  = (b == 8'hE0) || (b == 8'hF0) || (b == 8'hE1);
    is_junk = 0;
    foreach (JK[i]) if (JK[i] == b) is_junk = 1;
    if (m_skip > 0) m_skip--;
    else if (m_brk) begin
      if (!is_pfx) model_emit(b, m_ext, 1);
      m_ext = 0;
      m_brk = 0;
    end else if (m_ext) begin
      if (b == 8'hF0) m_brk = 1;
      else if (b != 8'hE0) begin
        model_emit(b, 1, 0);
        m_ext = 0;
      end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE1) m_skip = 7;
    else if (!is_junk) model_emit(b, 0, 0);
  endtask
  task automatic send(input logic [7:0] b, input int hold = 1, input int gap = 2);
    model_byte(b);
    @(posedge clk);
    #1 datain = b;
    dataready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 dataready = 1'b0;
    repeat (gap) @(posedge clk);
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1 vectors++;
    if ({key_valid, key_code, key_ext, key_break, ascii, shift_on, caps_on} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset outputs: got %h want 0", {key_valid, key_code, key_ext, key_break, ascii, shift_on, caps_on});
    end
    @(negedge clk) reset = 1'b0;
  endtask
  task automatic test_single;
    model_byte(8'h1C);
    @(posedge clk);
    #1 datain = 8'h1C;
    dataready = 1'b1;
    @(posedge clk);
    #1 dataready = 1'b0;
    vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL single early: key_valid %b want 0", key_valid); end
    @(posedge clk);
    #1 vectors++;
    if ({key_valid, key_code, key_ext, key_break, ascii} !== {1'b1, 8'h1C, 2'b00, 8'h61}) begin
      miscompares++;
      $display("FAIL single event: got v=%b code=%h e=%b b=%b a=%h want 1 1c 0 0 61", key_valid, key_code, key_ext, key_break, ascii);
    end
    @(posedge clk);
    #1 vectors++;
    if (key_valid !== 1'b0) begin miscompares++; $display("FAIL single pulse width: key_valid %b want 0", key_valid); end
    repeat (3) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL single count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_shift;
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    send(8'h59); send(8'h1A); send(8'hF0); send(8'h59); send(8'h1A);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL shift count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL shift ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_extended;
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hE0); send(8'h12); send(8'hF0); send(8'hE0); send(8'h29);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL ext count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ext ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_caps;
    send(8'h58); send(8'h58); send(8'h58); send(8'hF0); send(8'h58); send(8'h1C);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h58); send(8'h1C);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL caps count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL caps ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_pause;
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'h16); send(8'hAA); send(8'hFA); send(8'h00); send(8'hFF);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin miscompares++; $display("FAIL pause count: got %0d want 1", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL pause ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_timeout;
    send(8'hE0, 1, 1);
    repeat (TO + 4) @(posedge clk);
    m_ext = 0; m_brk = 0; m_skip = 0;
    #1 vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL timeout prefix event: got %0d want 0", obs_q.size()); end
    send(8'h1C);
    send(8'hF0, 1, 1);
    repeat (TO + 4) @(posedge clk);
    m_ext = 0; m_brk = 0; m_skip = 0;
    send(8'h1C);
    send(8'hE0, 1, 1);
    repeat (TO - 10) @(posedge clk);
    send(8'h75);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL timeout count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL timeout ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_hold;
    send(8'h1C, 50, 2);
    send(8'h32, 1, 1);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin miscompares++; $display("FAIL hold count: got %0d want 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL hold ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_random;
    logic [7:0] b;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : LT[$urandom_range(0, 25)];
        3: b = JK[$urandom_range(0, 5)];
        4: b = $urandom_range(0, 1) ? 8'h12 : 8'h59;
        5: b = 8'h58;
        6, 7: b = LT[$urandom_range(0, 25)];
        8: b = DG[$urandom_range(0, 9)];
        default: b = 8'($urandom);
      endcase
      send(b, $urandom_range(1, 4), $urandom_range(1, 5));
    end
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL random count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL random ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  task automatic test_reset_mid;
    send(8'h58); send(8'h12); send(8'hF0);
    vectors++;
    if ({shift_on, caps_on} !== 2'b11) begin miscompares++; $display("FAIL pre-reset levels: got %b want 11", {shift_on, caps_on}); end
    #2 reset = 1'b1;
    #1 vectors++;
    if ({key_valid, key_code, key_ext, key_break, ascii, shift_on, caps_on} !== 21'h0) begin
      miscompares++;
      $display("FAIL reset mid outputs: got %h want 0", {key_valid, key_code, key_ext, key_break, ascii, shift_on, caps_on});
    end
    @(negedge clk) reset = 1'b0;
    m_ext = 0; m_brk = 0; m_skip = 0; m_ls = 0; m_rs = 0; m_caps = 0; m_held = 0;
    obs_q.delete(); exp_q.delete();
    send(8'h1C);
    repeat (4) @(posedge clk);
    #1 vectors++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin miscompares++; $display("FAIL reset mid count: got %0d want 1", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      vectors++;
      if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL reset mid ev%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask
  initial begin
    test_reset;
    test_single;
    test_shift;
    test_extended;
    test_caps;
    test_pause;
    test_timeout;
    test_hold;
    test_random;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
